// File: rtl/pll_reset_seq.sv
// PLL lock -> core reset -> panel output-enable sequencer for the LED matrix.
// Optional lock-loss counter: define PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int OE_DELAY      = 256
) (
    input  logic       pll_clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       core_rst_n,
    output logic       panel_oe_n,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_CYC = (STABLE_CYCLES > OE_DELAY) ? STABLE_CYCLES : OE_DELAY;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OE_LAST     = CNT_W'(OE_DELAY - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, CORE_UP, RUN} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Lock loss always wins over a soft reset request arriving on the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (locked_s) state_nxt = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = CORE_UP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CORE_UP: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (soft_rst_req) begin
                    state_nxt = STABILIZE;
                    cnt_nxt   = '0;
                end else if (cnt == OE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
                if (!locked_s)         state_nxt = WAIT_LOCK;
                else if (soft_rst_req) state_nxt = STABILIZE;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            core_rst_n <= 1'b0;
            panel_oe_n <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            core_rst_n <= (state_nxt == CORE_UP) || (state_nxt == RUN);
            panel_oe_n <= (state_nxt != RUN);
            ready      <= (state_nxt == RUN);
        end
    end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    assign loss_evt = ((state == CORE_UP) || (state == RUN)) && !locked_s;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n)                          loss_q <= '0;
        else if (loss_evt && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule
